// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ctrl_pkg
//  Purpose  : Shared pipeline-control constants: stage indices, default
//             stage count and the pipe_ctrl FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Pipeline depth and stage indices (0 is the youngest stage)
  localparam int c_nstage_default = 6;
  localparam int c_stage_pc       = 0;
  localparam int c_stage_if       = 1;
  localparam int c_stage_id       = 2;
  localparam int c_stage_ex       = 3;
  localparam int c_stage_mem      = 4;
  localparam int c_stage_wb       = 5;

  // pipe_ctrl FSM encoding
  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_hold  = 2'd1;
  localparam logic [1:0] c_st_flush = 2'd2;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/stall_therm.sv
`default_nettype none
// ============================================================================
//  Module   : stall_therm
//  Purpose  : Priority-encode the highest set request bit k and expand it to
//             a thermometer mask with bits [k:0] set; no request -> all 0.
//  Revision : 1.0 - initial release
// ============================================================================
module stall_therm
  import cpu_ctrl_pkg::*;
#(
  parameter int NSTAGE = c_nstage_default
) (
  input  logic [NSTAGE-1:0] req,
  output logic [NSTAGE-1:0] therm
);

  logic w_acc;

  // Scan from the oldest stage down: once any older stage stalls, every
  // younger stage behind it must stall too.
  always_comb begin
    w_acc = 1'b0;
    therm = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      w_acc    = w_acc | req[i];
      therm[i] = w_acc;
    end
  end

endmodule : stall_therm
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Pipeline stall/flush controller with a fixed-length internal
//             hold (multi-cycle EX op), registered redirect pulse and a
//             consecutive-stall watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int NSTAGE     = c_nstage_default,
  parameter int HOLD_STAGE = c_stage_ex,
  parameter int CW         = 6,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  input  logic              hold_start,
  input  logic [CW-1:0]     hold_len,
  input  logic              timeout_clr,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              hold_busy,
  output logic              stall_timeout
);

  localparam int              c_wdw    = $clog2(TIMEOUT + 1);
  localparam logic [c_wdw-1:0] c_wd_max = c_wdw'(TIMEOUT);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nx;
  logic [CW-1:0]     r_hold_cnt;
  logic [CW-1:0]     w_hold_cnt_nx;
  logic [31:0]       r_new_pc;
  logic [c_wdw-1:0]  r_wd_cnt;
  logic [c_wdw-1:0]  w_wd_cnt_nx;
  logic              r_timeout;
  logic              w_in_flush;
  logic              w_in_hold;
  logic [NSTAGE-1:0] w_hold_bit;
  logic [NSTAGE-1:0] w_src;
  logic [NSTAGE-1:0] w_therm;

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= c_st_run;
    else         r_state <= w_state_nx;
  end

  // FSM next state and hold-counter next value; a flush request always wins
  always_comb begin
    w_state_nx    = r_state;
    w_hold_cnt_nx = r_hold_cnt;
    case (r_state)
      c_st_run: begin
        if (flush_req) begin
          w_state_nx    = c_st_flush;
          w_hold_cnt_nx = '0;
        end else if (hold_start && (hold_len != '0)) begin
          w_state_nx    = c_st_hold;
          w_hold_cnt_nx = hold_len;
        end
      end
      c_st_hold: begin
        if (flush_req) begin
          w_state_nx    = c_st_flush;
          w_hold_cnt_nx = '0;
        end else begin
          w_hold_cnt_nx = r_hold_cnt - 1'b1;
          if (r_hold_cnt <= CW'(1)) w_state_nx = c_st_run;
        end
      end
      c_st_flush: begin
        w_hold_cnt_nx = '0;
        w_state_nx    = flush_req ? c_st_flush : c_st_run;
      end
      default: begin
        w_state_nx    = c_st_run;
        w_hold_cnt_nx = '0;
      end
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    w_in_flush = (r_state == c_st_flush);
    w_in_hold  = (r_state == c_st_hold);
  end

  // Hold counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_hold_cnt <= '0;
    else         r_hold_cnt <= w_hold_cnt_nx;
  end

  // Redirect target, captured with every flush request and held otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        r_new_pc <= '0;
    else if (flush_req) r_new_pc <= flush_pc;
  end

  // Stall sources: external requests (stage 0 cannot request) plus the hold
  always_comb begin
    w_hold_bit = w_in_hold ? (NSTAGE'(1) << HOLD_STAGE) : '0;
    w_src      = (stall_req & ~NSTAGE'(1)) | w_hold_bit;
  end

  stall_therm #(
    .NSTAGE (NSTAGE)
  ) u_stall_therm (
    .req   (w_src),
    .therm (w_therm)
  );

  // Flush cycles and reset override every stall source
  always_comb begin
    stall = (resetn && !w_in_flush) ? w_therm : '0;
  end

  // Watchdog next count: saturating run length of stalled cycles
  always_comb begin
    if (|stall) w_wd_cnt_nx = (r_wd_cnt == c_wd_max) ? r_wd_cnt : r_wd_cnt + 1'b1;
    else        w_wd_cnt_nx = '0;
  end

  // Watchdog counter and sticky flag; clear beats a same-cycle set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_cnt_nx;
      if (timeout_clr)                   r_timeout <= 1'b0;
      else if (w_wd_cnt_nx == c_wd_max)  r_timeout <= 1'b1;
    end
  end

  assign flush         = w_in_flush;
  assign hold_busy     = w_in_hold;
  assign new_pc        = r_new_pc;
  assign stall_timeout = r_timeout;

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Self-checking bench for pipe_ctrl: directed scenarios with
//             literal expectations, then randomized traffic against a
//             cycle-level behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int NS  = 6;
  localparam int HS  = 3;
  localparam int TO  = 8;

  logic        clk;
  logic        resetn;
  logic [5:0]  stall_req;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        hold_start;
  logic [5:0]  hold_len;
  logic        timeout_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        hold_busy;
  logic        stall_timeout;

  pipe_ctrl #(
    .NSTAGE     (NS),
    .HOLD_STAGE (HS),
    .CW         (6),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .stall_req     (stall_req),
    .flush_req     (flush_req),
    .flush_pc      (flush_pc),
    .hold_start    (hold_start),
    .hold_len      (hold_len),
    .timeout_clr   (timeout_clr),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .hold_busy     (hold_busy),
    .stall_timeout (stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: remaining hold cycles, pending flush pulse, pc,
  // current stalled-run length and sticky timeout flag.
  int          m_hold_left;
  bit          m_flush;
  logic [31:0] m_pc;
  int          m_wd;
  bit          m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_stall();
    int k;
    logic [5:0] v;
    v = '0;
    k = -1;
    if (!resetn || m_flush) return 6'd0;
    for (int i = 1; i < NS; i++) if (stall_req[i]) k = i;
    if (m_hold_left > 0 && HS > k) k = HS;
    for (int j = 0; j <= k; j++) v[j] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_hold_left = 0;
    m_flush     = 1'b0;
    m_pc        = '0;
    m_wd        = 0;
    m_to        = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held across it
  task automatic model_update();
    logic [5:0] s;
    bit was_flush;
    s = exp_stall();
    was_flush = m_flush;
    if (flush_req) begin
      m_flush     = 1'b1;
      m_pc        = flush_pc;
      m_hold_left = 0;
    end else begin
      m_flush = 1'b0;
      if (m_hold_left > 0) m_hold_left--;
      else if (!was_flush && hold_start && hold_len != 0) m_hold_left = int'(hold_len);
    end
    if (s != 0) m_wd = (m_wd < TO) ? m_wd + 1 : TO;
    else        m_wd = 0;
    if (timeout_clr)    m_to = 1'b0;
    else if (m_wd == TO) m_to = 1'b1;
  endtask

  // Compare every output against the model once per cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",         {26'd0, stall},         {26'd0, exp_stall()});
      check("flush",         {31'd0, flush},         {31'd0, m_flush});
      check("hold_busy",     {31'd0, hold_busy},     (m_hold_left > 0) ? 32'd1 : 32'd0);
      check("new_pc",        new_pc,                 m_pc);
      check("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
    end
  end

  task automatic tick();
    @(posedge clk);
    if (resetn) model_update();
    #1;
  endtask

  task automatic wait_mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    stall_req   = '0;
    flush_req   = 1'b0;
    flush_pc    = '0;
    hold_start  = 1'b0;
    hold_len    = '0;
    timeout_clr = 1'b0;
  endtask

  initial begin
    idle();
    model_reset();
    resetn    = 1'b0;
    stall_req = 6'b111111;
    repeat (2) @(posedge clk);
    #1;
    wait_mid();
    check("rst_stall",   {26'd0, stall},         32'd0);
    check("rst_flush",   {31'd0, flush},         32'd0);
    check("rst_busy",    {31'd0, hold_busy},     32'd0);
    check("rst_pc",      new_pc,                 32'd0);
    check("rst_timeout", {31'd0, stall_timeout}, 32'd0);
    tick();
    resetn = 1'b1;
    idle();
    chk_en = 1'b1;

    // Thermometer stall patterns
    stall_req = 6'b001000; wait_mid(); check("therm_b3",  {26'd0, stall}, 32'h0F); tick();
    stall_req = 6'b001100; wait_mid(); check("therm_b32", {26'd0, stall}, 32'h0F); tick();
    stall_req = 6'b000100; wait_mid(); check("therm_b2",  {26'd0, stall}, 32'h07); tick();
    stall_req = 6'b000001; wait_mid(); check("therm_b0",  {26'd0, stall}, 32'h00); tick();
    idle(); tick();

    // Fixed-length hold of 4 cycles
    hold_start = 1'b1; hold_len = 6'd4; tick();
    idle();
    for (int c = 0; c < 4; c++) begin
      wait_mid();
      check("hold4_busy",  {31'd0, hold_busy}, 32'd1);
      check("hold4_stall", {26'd0, stall},     32'h0F);
      tick();
    end
    wait_mid();
    check("hold4_end_busy",  {31'd0, hold_busy}, 32'd0);
    check("hold4_end_stall", {26'd0, stall},     32'd0);
    tick();

    // Flush arriving in the second hold cycle
    hold_start = 1'b1; hold_len = 6'd4; tick();
    idle(); tick();
    flush_req = 1'b1; flush_pc = 32'hBFC0_0380; tick();
    idle(); stall_req = 6'b010000;
    wait_mid();
    check("fl_hold_flush", {31'd0, flush},     32'd1);
    check("fl_hold_pc",    new_pc,             32'hBFC0_0380);
    check("fl_hold_stall", {26'd0, stall},     32'd0);
    check("fl_hold_busy",  {31'd0, hold_busy}, 32'd0);
    tick();
    idle();
    wait_mid();
    check("fl_after_flush", {31'd0, flush}, 32'd0);
    check("fl_after_pc",    new_pc,         32'hBFC0_0380);
    tick();

    // Back-to-back flush requests
    flush_req = 1'b1; flush_pc = 32'h0000_1000; tick();
    flush_pc = 32'h0000_2000;
    wait_mid(); check("fl3_a_flush", {31'd0, flush}, 32'd1); check("fl3_a_pc", new_pc, 32'h0000_1000); tick();
    flush_pc = 32'h0000_3000;
    wait_mid(); check("fl3_b_flush", {31'd0, flush}, 32'd1); check("fl3_b_pc", new_pc, 32'h0000_2000); tick();
    idle();
    wait_mid(); check("fl3_c_flush", {31'd0, flush}, 32'd1); check("fl3_c_pc", new_pc, 32'h0000_3000); tick();
    wait_mid(); check("fl3_d_flush", {31'd0, flush}, 32'd0); check("fl3_d_pc", new_pc, 32'h0000_3000); tick();

    // Watchdog after 8 consecutive stalled cycles
    stall_req = 6'b001000;
    for (int c = 0; c < TO; c++) begin
      wait_mid();
      check("wd_pre", {31'd0, stall_timeout}, 32'd0);
      tick();
    end
    stall_req = '0;
    wait_mid(); check("wd_set", {31'd0, stall_timeout}, 32'd1);
    timeout_clr = 1'b1; tick();
    timeout_clr = 1'b0;
    wait_mid(); check("wd_clr", {31'd0, stall_timeout}, 32'd0);
    tick();

    // Asynchronous reset in the middle of a long hold
    hold_start = 1'b1; hold_len = 6'd10; tick();
    idle(); tick(); tick();
    stall_req = 6'b100000;
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("arst_stall", {26'd0, stall},         32'd0);
    check("arst_busy",  {31'd0, hold_busy},     32'd0);
    check("arst_flush", {31'd0, flush},         32'd0);
    check("arst_pc",    new_pc,                 32'd0);
    check("arst_to",    {31'd0, stall_timeout}, 32'd0);
    tick();
    resetn = 1'b1;
    idle();
    hold_start = 1'b1; hold_len = 6'd3; tick();
    idle();
    wait_mid(); check("post_rst_hold", {31'd0, hold_busy}, 32'd1);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) stall_req = 6'($urandom);
      flush_req   = ($urandom_range(0, 11) == 0);
      flush_pc    = $urandom;
      hold_start  = ($urandom_range(0, 4) == 0);
      hold_len    = 6'($urandom_range(0, 7));
      timeout_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #2;
        resetn = 1'b0;
        model_reset();
        tick();
        resetn = 1'b1;
      end else begin
        tick();
      end
    end

    idle();
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pipe_ctrl
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 6: stage count; index 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
REQ-002 SHALL have parameter HOLD_STAGE, default 3: stage stalled by an internal hold.
REQ-003 SHALL have parameter CW, default 6: hold-length counter width.
REQ-004 SHALL have parameter TIMEOUT, default 1023: consecutive-stall watchdog limit.
REQ-005 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-006 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port stall_req, input, NSTAGE: bit i = stage i requests stall; bit 0 ignored.
REQ-008 SHALL have port flush_req, input, 1: exception/redirect request.
REQ-009 SHALL have port flush_pc, input, 32: redirect target sampled with flush_req.
REQ-010 SHALL have port hold_start, input, 1: begin fixed-length hold (multi-cycle EX op).
REQ-011 SHALL have port hold_len, input, CW: hold length in cycles.
REQ-012 SHALL have port timeout_clr, input, 1: clears stall_timeout.
REQ-013 SHALL have port stall, output, NSTAGE: bit i=1 freezes stage i.
REQ-014 SHALL have port flush, output, 1: one-cycle registered flush pulse.
REQ-015 SHALL have port new_pc, output, 32: redirect target, valid when flush=1.
REQ-016 SHALL have port hold_busy, output, 1: hold counter active.
REQ-017 SHALL have port stall_timeout, output, 1: sticky watchdog flag.

Function
REQ-018 SHALL compute stall combinationally: k = highest index among stall_req[NSTAGE-1:1] and HOLD_STAGE when hold_busy=1; stall[k:0]=1, others 0; no source -> all 0.
REQ-019 SHALL implement FSM RUN, HOLD, FLUSH; reset state RUN.
REQ-020 SHALL on flush_req=1 in any state: next state FLUSH; latch flush_pc into new_pc; clear hold counter.
REQ-021 SHALL in FLUSH: flush=1 for exactly that cycle, stall all 0 regardless of requests; exit to RUN, or FLUSH again if flush_req=1.
REQ-022 SHALL flush latency: flush_req at edge t -> flush=1 during cycle t+1.
REQ-023 SHALL keep new_pc at last latched value when flush=0.
REQ-024 SHALL in RUN with hold_start=1, hold_len>0, flush_req=0: load counter with hold_len, enter HOLD; hold_busy=1 for exactly hold_len cycles.
REQ-025 SHALL ignore hold_start when hold_len=0, when already in HOLD, or when flush_req=1.
REQ-026 SHALL decrement counter each HOLD cycle; counter 1 -> RUN next edge.
REQ-027 SHALL count consecutive cycles with any stall bit set, saturating at TIMEOUT; reset to 0 on any cycle with stall all 0.
REQ-028 SHALL set stall_timeout when count reaches TIMEOUT; hold until timeout_clr=1 (clr wins over set same cycle).

Reset
REQ-029 SHALL asynchronously on resetn=0 force: state RUN, hold counter 0, watchdog 0, new_pc 0, flush 0, hold_busy 0, stall_timeout 0.
REQ-030 SHALL drive stall all 0 while resetn=0, ignoring stall_req.
REQ-031 SHALL abort any hold or flush in progress on reset; first post-reset cycle behaves as RUN.

Structure
REQ-032 SHALL place stage-index constants (PC..WB), FSM state encoding and default NSTAGE in shared package cpu_ctrl_pkg.
REQ-033 SHALL implement priority encode + thermometer expansion as sub-module stall_therm (NSTAGE-wide, combinational).

Verification
REQ-034 SHALL cover: stall_req=6'b001000 -> stall=6'b001111; add bit2 -> unchanged; only bit2 -> 6'b000111.
REQ-035 SHALL cover: hold_start, hold_len=4 -> hold_busy and stall=6'b001111 for exactly 4 cycles, then 0.
REQ-036 SHALL cover: flush_req, flush_pc=0xBFC00380 during hold cycle 2 -> next cycle flush=1, new_pc=0xBFC00380, stall=0, hold_busy=0.
REQ-037 SHALL cover: flush_req held 3 cycles -> flush=1 three consecutive cycles, new_pc tracks each flush_pc.
REQ-038 SHALL cover: TIMEOUT=8, stall_req bit3 held 8 cycles -> stall_timeout=1; release, timeout_clr -> 0.
REQ-039 SHALL cover: resetn low mid-hold (len 10) -> all outputs 0 immediately; after release, hold_start accepted.
